// File: rtl/cl_pkg.sv
// Shared definitions for the bit-serial logic unit: operation codes and FSM encoding.
package cl_pkg;

   localparam logic [1:0] CLOP_AND  = 2'b00;
   localparam logic [1:0] CLOP_OR   = 2'b01;
   localparam logic [1:0] CLOP_XOR  = 2'b10;
   localparam logic [1:0] CLOP_XNOR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/cl_bit.sv
// 1-bit logic cell: out = f(a, b) selected by clop (AND, OR, XOR, XNOR).
module cl_bit
   import cl_pkg::*;
(
   output logic       out,
   input  logic       a,
   input  logic       b,
   input  logic [1:0] clop
);

   always_comb begin
      out = 1'b0;
      case (clop)
         CLOP_AND: out = a & b;
         CLOP_OR:  out = a | b;
         CLOP_XOR: out = a ^ b;
         default:  out = ~(a ^ b);
      endcase
   end

endmodule

// File: rtl/cl_serial_unit.sv
// Bit-serial WIDTH-bit logic unit: streams operands LSB-first through cl_bit
// and reassembles the result word behind valid/ready handshakes on both sides.
module cl_serial_unit
   import cl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_clop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             busy,
   output logic [1:0]       fsm_state
);

   // Handshake rule (both sides): a word transfers on a rising edge where
   // valid and ready are both 1; the producer holds data while ready is 0.

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic [1:0]       op;
   logic [CW-1:0]    cnt;
   logic             cell_bit;
   logic             ready_q;
   logic             valid_q;
   logic             busy_q;
   logic             zero_q;

   cl_bit u_cell (
      .out  (cell_bit),
      .a    (sa[0]),
      .b    (sb[0]),
      .clop (op)
   );

   // Each new result bit enters at the MSB so the LSB-first stream lands in order.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_next = cell_bit;
      end else begin : g_res_wn
         assign res_next = {cell_bit, res[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         sa      <= '0;
         sb      <= '0;
         res     <= '0;
         op      <= CLOP_AND;
         cnt     <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && ready_q) begin
                  sa      <= in_a;
                  sb      <= in_b;
                  op      <= in_clop;
                  cnt     <= '0;
                  state   <= ST_SHIFT;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               res <= res_next;
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               cnt <= cnt + CW'(1);
               if (cnt == CNT_LAST) begin
                  state   <= ST_DONE;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b1;
                  zero_q  <= (res_next == '0);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state   <= ST_IDLE;
                  valid_q <= 1'b0;
                  zero_q  <= 1'b0;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               zero_q  <= 1'b0;
            end
         endcase
      end
   end

   // Gating with rst_n keeps in_ready low during reset yet high right after release.
   assign in_ready   = ready_q & rst_n;
   assign out_valid  = valid_q;
   assign busy       = busy_q;
   assign out_zero   = zero_q;
   assign out_result = res;
   assign fsm_state  = state;

endmodule

// File: tb/tb_cl_serial_unit.sv
// Directed bench for cl_serial_unit: WIDTH=8 main instance plus a WIDTH=1 instance.
module tb_cl_serial_unit;
   import cl_pkg::*;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [1:0]   in_clop;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic         out_zero;
   logic         busy;
   logic [1:0]   fsm_state;

   logic         w1_in_valid;
   logic         w1_in_ready;
   logic [0:0]   w1_in_a;
   logic [0:0]   w1_in_b;
   logic [1:0]   w1_in_clop;
   logic         w1_out_valid;
   logic         w1_out_ready;
   logic [0:0]   w1_out_result;
   logic         w1_out_zero;
   logic         w1_busy;
   logic [1:0]   w1_fsm_state;

   int n_pass;
   int n_total;
   int cyc;
   int acc_cyc[3];

   cl_serial_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_clop    (in_clop),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .busy       (busy),
      .fsm_state  (fsm_state)
   );

   cl_serial_unit #(.WIDTH(1)) dut_w1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (w1_in_valid),
      .in_ready   (w1_in_ready),
      .in_a       (w1_in_a),
      .in_b       (w1_in_b),
      .in_clop    (w1_in_clop),
      .out_valid  (w1_out_valid),
      .out_ready  (w1_out_ready),
      .out_result (w1_out_result),
      .out_zero   (w1_out_zero),
      .busy       (w1_busy),
      .fsm_state  (w1_fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("wait_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("wait_out_valid", 32'(out_valid), 32'd1);
   endtask

   // Accept one word and run it to DONE; optionally scramble inputs during SHIFT.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         input logic [W-1:0] exp, input bit disturb, input string tag);
      wait_ready();
      in_a = a;
      in_b = b;
      in_clop = op;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk({tag, "_busy_start"}, 32'(busy), 32'd1);
      chk({tag, "_in_ready_shift"}, 32'(in_ready), 32'd0);
      for (int i = 1; i < W; i++) begin
         if (disturb && i == 2) begin
            in_a = ~a;
            in_b = 8'hFF;
            in_clop = op ^ 2'b01;
         end
         tick();
      end
      chk({tag, "_busy_last"}, 32'(busy), 32'd1);
      chk({tag, "_valid_early"}, 32'(out_valid), 32'd0);
      tick();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
      chk({tag, "_result"}, 32'(out_result), 32'(exp));
      chk({tag, "_zero"}, 32'(out_zero), 32'(exp == '0));
   endtask

   task automatic take(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_clop = 2'b00;
      out_ready = 1'b0;
      w1_in_valid = 1'b0;
      w1_in_a = '0;
      w1_in_b = '0;
      w1_in_clop = 2'b00;
      w1_out_ready = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_in_ready_held", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", 32'(out_result), 32'd0);
      chk("rst_zero", 32'(out_zero), 32'd0);
      chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready_released", 32'(in_ready), 32'd1);
      tick();

      // the four operations on A5/0F, then an all-zero result
      run_op(8'hA5, 8'h0F, CLOP_AND,  8'h05, 1'b0, "and");  take("and");
      run_op(8'hA5, 8'h0F, CLOP_OR,   8'hAF, 1'b0, "or");   take("or");
      run_op(8'hA5, 8'h0F, CLOP_XOR,  8'hAA, 1'b0, "xor");  take("xor");
      run_op(8'hA5, 8'h0F, CLOP_XNOR, 8'h55, 1'b0, "xnor"); take("xnor");
      run_op(8'hF0, 8'h0F, CLOP_AND,  8'h00, 1'b0, "zero"); take("zero");

      // backpressure: result held, new offers ignored
      run_op(8'hA5, 8'h0F, CLOP_AND, 8'h05, 1'b0, "bp");
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_a = 8'h3C;
         in_clop = CLOP_XOR;
         tick();
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_result", 32'(out_result), 32'h05);
         chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      take("bp");

      // inputs changed mid-SHIFT do not affect the latched operation
      run_op(8'hA5, 8'h0F, CLOP_AND, 8'h05, 1'b1, "disturb");
      take("disturb");

      // reset during SHIFT aborts the transaction
      in_a = 8'hA5;
      in_b = 8'h0F;
      in_clop = CLOP_OR;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("mid_rst_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_result", 32'(out_result), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
      end
      run_op(8'h3C, 8'hFF, CLOP_XOR, 8'hC3, 1'b0, "post_rst");
      take("post_rst");

      // back-to-back with in_valid and out_ready tied high
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_a = 8'hA5; in_b = 8'h0F; in_clop = CLOP_AND;
      for (int w = 0; w < 3; w++) begin
         wait_ready();
         tick();
         acc_cyc[w] = cyc;
         if (w == 0) begin
            in_a = 8'hF0; in_b = 8'h0F; in_clop = CLOP_XOR;
         end else begin
            in_a = 8'h3C; in_b = 8'hFF; in_clop = CLOP_XNOR;
         end
         wait_valid();
         case (w)
            0: chk("b2b_result0", 32'(out_result), 32'h05);
            1: chk("b2b_result1", 32'(out_result), 32'hFF);
            default: chk("b2b_result2", 32'(out_result), 32'h3C);
         endcase
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("b2b_spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
      chk("b2b_spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));

      // WIDTH=1 instance: a=1, b=0, OR
      chk("w1_ready", 32'(w1_in_ready), 32'd1);
      w1_in_a = 1'b1;
      w1_in_b = 1'b0;
      w1_in_clop = CLOP_OR;
      w1_in_valid = 1'b1;
      tick();
      w1_in_valid = 1'b0;
      chk("w1_busy", 32'(w1_busy), 32'd1);
      chk("w1_valid_early", 32'(w1_out_valid), 32'd0);
      tick();
      chk("w1_valid", 32'(w1_out_valid), 32'd1);
      chk("w1_result", 32'(w1_out_result), 32'd1);
      chk("w1_zero", 32'(w1_out_zero), 32'd0);
      w1_out_ready = 1'b1;
      tick();
      w1_out_ready = 1'b0;
      chk("w1_idle_ready", 32'(w1_in_ready), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
